sprite_dma: RTL

SPRITE_DMA -- requirements
Module: sprite_dma

---
 rtl/sprite_dma.sv | 115 +++++++++++
 1 files changed

// File: rtl/sprite_dma.sv
// rtl/sprite_dma.sv - OAM sprite DMA engine: stalls the CPU and copies one 256-byte page to OAMDATA
//
// Purpose: watches the CPU bus for a write to P_DMA_REG. On a hit it stalls the CPU,
// optionally burns one alignment cycle, and then alternates read/write bus cycles.
// Each cycle reads {page,index} and writes that byte to P_OAM_DATA, for 256 bytes.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_reset_n   asynchronous active-low reset
//   i_ce        clock enable; all state advances only when high
//   i_address   CPU address bus (trigger detection)
//   i_rw        CPU read/write, 1 = read
//   i_data      CPU write data in IDLE, memory read data in READ
//   o_rdy       CPU ready, 0 stalls the CPU
//   o_bus_en    1 while the DMA drives address/data/rw
//   o_address   DMA bus address
//   o_rw        DMA read/write, 1 = read
//   o_data      DMA write data
module sprite_dma #(
  parameter logic [15:0] P_DMA_REG  = 16'h4014,
  parameter logic [15:0] P_OAM_DATA = 16'h2004
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_ce,
  input  logic [15:0] i_address,
  input  logic        i_rw,
  input  logic [7:0]  i_data,
  output logic        o_rdy,
  output logic        o_bus_en,
  output logic [15:0] o_address,
  output logic        o_rw,
  output logic [7:0]  o_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        parity_q, parity_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  index_q, index_d;
  logic [7:0]  data_q, data_d;

  always_comb begin
    state_d  = state_q;
    parity_d = ~parity_q;
    page_d   = page_q;
    index_d  = index_q;
    data_d   = data_q;
    case (state_q)
      S_IDLE: begin
        if (!i_rw && (i_address == P_DMA_REG)) begin
          page_d  = i_data;
          index_d = 8'h00;
          state_d = S_HALT;
        end
      end
      // Parity 1 in HALT means the next cycle is a read slot; otherwise
      // one dummy cycle lines the reads up with parity 0.
      S_HALT:  state_d = parity_q ? S_READ : S_ALIGN;
      S_ALIGN: state_d = S_READ;
      S_READ: begin
        data_d  = i_data;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        index_d = index_q + 8'd1;
        state_d = (index_q == 8'hFF) ? S_IDLE : S_READ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      parity_q <= 1'b0;
      page_q   <= 8'h00;
      index_q  <= 8'h00;
      data_q   <= 8'h00;
    end else if (i_ce) begin
      state_q  <= state_d;
      parity_q <= parity_d;
      page_q   <= page_d;
      index_q  <= index_d;
      data_q   <= data_d;
    end
  end

  // Outputs decode directly from registered state so they follow reset
  // immediately and hold while i_ce is low.
  always_comb begin
    o_rdy     = (state_q == S_IDLE);
    o_bus_en  = 1'b0;
    o_address = 16'h0000;
    o_rw      = 1'b1;
    o_data    = 8'h00;
    if (state_q == S_READ) begin
      o_bus_en  = 1'b1;
      o_address = {page_q, index_q};
    end else if (state_q == S_WRITE) begin
      o_bus_en  = 1'b1;
      o_address = P_OAM_DATA;
      o_rw      = 1'b0;
      o_data    = data_q;
    end
  end

endmodule
